stream_prefetch: RTL and testbench
==================================

STREAM_PREFETCH -- requirements
Module: stream_prefetch

Interface
REQ-001 SHALL take parameter NUM_STREAMS, default 4, number of tracked streams (>=1).
REQ-002 SHALL take parameter LINE_BYTES, default 32, cache line size in bytes (power of 2, 4..4096).
REQ-003 SHALL take parameter DEGREE, default 2, lines prefetched per trigger (1..8).
REQ-004 SHALL take parameter CONF_THRESH, default 2, confidence needed to trigger (1..3).
REQ-005 SHALL have one clock and asynchronous active-high reset: clk in 1, rising-edge clock; rst in 1, asynchronous active-high reset.
REQ-006 SHALL have miss_valid in 1, demand miss observed this cycle.
REQ-007 SHALL have miss_addr in 32, demand miss byte address.
REQ-008 SHALL have flush in 1, branch/pipeline redirect, aborts prefetching.
REQ-009 SHALL have pf_valid out 1, prefetch request valid.
REQ-010 SHALL have pf_addr out 32, line-aligned prefetch address.
REQ-011 SHALL have pf_ready in 1, memory side accepts request.
REQ-012 SHALL have busy out 1, high while a prefetch burst is in progress.

Function
REQ-013 SHALL hold per entry: valid, last_line (32 - log2(LINE_BYTES) bits), dir (0 up, 1 down), 2-bit saturating conf.
REQ-014 SHALL compute miss_line = miss_addr / LINE_BYTES and train the table on every cycle with miss_valid=1 and flush=0, in both states.
REQ-015 SHALL match an entry if it is valid and miss_line == last_line+1 (up) or last_line-1 (down), modulo line-address width; on multiple matches the lowest index wins.
REQ-016 SHALL, on a match with the same dir, set conf = min(conf+1, 3); with a different dir, set dir to the new direction and conf = 1; in both cases last_line = miss_line.
REQ-017 SHALL, on no match, allocate the lowest-index invalid entry, else the entry at a round-robin victim pointer that then increments modulo NUM_STREAMS; the new entry gets valid=1, last_line=miss_line, dir=up, conf=0.
REQ-018 SHALL use a two-state FSM, IDLE and ISSUE.
REQ-019 SHALL move IDLE->ISSUE when the updated conf >= CONF_THRESH, latching base=miss_line, dir, page=miss_addr[31:12], and k=1.
REQ-020 SHALL train, but not retrigger, on misses in ISSUE; the trigger is dropped.
REQ-021 SHALL drive pf_valid=1 with pf_addr = (base + k or base - k) * LINE_BYTES while in ISSUE, with the low log2(LINE_BYTES) bits zero and the arithmetic modulo 2^32.
REQ-022 SHALL assert pf_valid in the cycle after the triggering miss (latency 1).
REQ-023 SHALL hold pf_valid and pf_addr stable until pf_ready=1; on each handshake k increments, and after the DEGREE-th handshake the FSM returns to IDLE with pf_valid=0 the next cycle.
REQ-024 SHALL end the burst with no request issued (ISSUE->IDLE) when the next pf_addr[31:12] != page, so no request ever crosses a 4 KiB page; this includes 32-bit wrap.
REQ-025 SHALL, on flush=1, go to IDLE, drop pf_valid the next cycle, and clear conf in all entries while keeping valid, last_line and dir.
REQ-026 SHALL ignore the same-cycle miss when flush and miss_valid coincide.
REQ-027 SHALL drive busy=1 iff the state is ISSUE.

Reset
REQ-028 SHALL, on rst (asynchronous, any cycle including mid-burst), clear all entry valid and conf bits, set the victim pointer to 0, and set the state to IDLE, giving pf_valid=0, pf_addr=0 and busy=0 immediately.
REQ-029 SHALL issue no request in the first cycle after rst deasserts unless a trigger occurred in that cycle.

Verification
REQ-030 SHALL cover: defaults, pf_ready=1, misses 0x1000, 0x1020, 0x1040 on consecutive cycles -> pf_addr 0x1060 then 0x1080, then busy=0.
REQ-031 SHALL cover: misses 0x2080, 0x2060, 0x2040 -> pf_addr 0x2020 then 0x2000.
REQ-032 SHALL cover: misses 0x1F80, 0x1FA0, 0x1FC0 -> only 0x1FE0 issued; the 0x2000 request is suppressed.
REQ-033 SHALL cover: pf_ready held low 3 cycles during the 0x1060 request -> pf_addr stays 0x1060 and pf_valid stays 1 for 4 cycles, then 0x1080 follows.
REQ-034 SHALL cover: flush in the cycle after 0x1060 is accepted -> no 0x1080 request; a following miss 0x1060 gives conf=1 and no trigger.
REQ-035 SHALL cover: NUM_STREAMS=2 with interleaved streams 0x1000.., 0x8000.., 0x4000 -> the 0x4000 miss evicts entry 0 (victim pointer 0), and the 0x8000 stream continues to trigger.

Source files
------------

// File: rtl/stream_prefetch.sv
// Stream prefetcher: learns up/down line-stride miss streams in a small table and,
// once a stream is confident enough, issues a burst of prefetches that stays inside one 4 KiB page.
module stream_prefetch #(
    parameter int NUM_STREAMS = 4,
    parameter int LINE_BYTES  = 32,
    parameter int DEGREE      = 2,
    parameter int CONF_THRESH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        miss_valid,
    input  logic [31:0] miss_addr,
    input  logic        flush,
    output logic        pf_valid,
    output logic [31:0] pf_addr,
    input  logic        pf_ready,
    output logic        busy
);
    localparam int LB = $clog2(LINE_BYTES);
    localparam int LW = 32 - LB;
    localparam int PW = (NUM_STREAMS > 1) ? $clog2(NUM_STREAMS) : 1;

    typedef logic [LW-1:0] line_t;
    typedef enum logic {IDLE, ISSUE} state_t;

    // Line index +/- k, turned back into a line-aligned byte address (wraps mod 2^32).
    function automatic logic [31:0] line_addr(input line_t b, input logic d, input logic [3:0] k);
        line_t l;
        l = d ? (b - line_t'(k)) : (b + line_t'(k));
        return {l, {LB{1'b0}}};
    endfunction

    logic [NUM_STREAMS-1:0]         valid_q, valid_d;
    logic [NUM_STREAMS-1:0][LW-1:0] last_q, last_d;
    logic [NUM_STREAMS-1:0]         dir_q, dir_d;
    logic [NUM_STREAMS-1:0][1:0]    conf_q, conf_d;
    logic [PW-1:0]                  vptr_q, vptr_d;
    state_t                         state_q, state_d;
    line_t                          base_q, base_d;
    logic                           pdir_q, pdir_d;
    logic [19:0]                    page_q, page_d;
    logic [3:0]                     k_q, k_d;

    line_t       miss_line, up_l, dn_l;
    logic        train, hit, hit_dir, free;
    int          hit_idx, free_idx, alloc_idx;
    logic [1:0]  upd_conf;
    logic [31:0] first_addr, next_addr;
    logic        unused_lo;

    assign miss_line = miss_addr[31:LB];
    assign unused_lo = ^miss_addr[LB-1:0];

    // Table training, victim selection and the IDLE/ISSUE burst controller.
    always_comb begin
        valid_d    = valid_q;
        last_d     = last_q;
        dir_d      = dir_q;
        conf_d     = conf_q;
        vptr_d     = vptr_q;
        state_d    = state_q;
        base_d     = base_q;
        pdir_d     = pdir_q;
        page_d     = page_q;
        k_d        = k_q;
        train      = miss_valid && !flush;
        hit        = 1'b0;
        hit_dir    = 1'b0;
        hit_idx    = 0;
        free       = 1'b0;
        free_idx   = 0;
        alloc_idx  = 0;
        upd_conf   = 2'd0;
        up_l       = '0;
        dn_l       = '0;
        first_addr = line_addr(miss_line, 1'b0, 4'd1);
        next_addr  = line_addr(base_q, pdir_q, k_q + 4'd1);

        // Scan high to low so the lowest matching / free index is what remains.
        for (int i = NUM_STREAMS - 1; i >= 0; i--) begin
            up_l = last_q[i] + line_t'(1);
            dn_l = last_q[i] - line_t'(1);
            if (valid_q[i] && (miss_line == up_l || miss_line == dn_l)) begin
                hit     = 1'b1;
                hit_idx = i;
                hit_dir = (miss_line != up_l);
            end
            if (!valid_q[i]) begin
                free     = 1'b1;
                free_idx = i;
            end
        end

        if (train) begin
            if (hit) begin
                if (dir_q[hit_idx] == hit_dir)
                    upd_conf = (conf_q[hit_idx] == 2'd3) ? 2'd3 : conf_q[hit_idx] + 2'd1;
                else
                    upd_conf = 2'd1;
                dir_d[hit_idx]  = hit_dir;
                conf_d[hit_idx] = upd_conf;
                last_d[hit_idx] = miss_line;
            end else begin
                if (free) begin
                    alloc_idx = free_idx;
                end else begin
                    alloc_idx = int'(vptr_q);
                    vptr_d    = (vptr_q == PW'(NUM_STREAMS - 1)) ? '0 : vptr_q + PW'(1);
                end
                valid_d[alloc_idx] = 1'b1;
                last_d[alloc_idx]  = miss_line;
                dir_d[alloc_idx]   = 1'b0;
                conf_d[alloc_idx]  = 2'd0;
            end
        end

        first_addr = line_addr(miss_line, hit_dir, 4'd1);

        case (state_q)
            IDLE: begin
                // A trigger whose very first line leaves the page issues nothing.
                if (train && hit && upd_conf >= 2'(CONF_THRESH) &&
                    first_addr[31:12] == miss_addr[31:12]) begin
                    state_d = ISSUE;
                    base_d  = miss_line;
                    pdir_d  = hit_dir;
                    page_d  = miss_addr[31:12];
                    k_d     = 4'd1;
                end
            end
            ISSUE: begin
                if (pf_ready) begin
                    if (k_q == 4'(DEGREE) || next_addr[31:12] != page_q)
                        state_d = IDLE;
                    else
                        k_d = k_q + 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Redirect: abort the burst and forget confidence, but keep stream positions.
        if (flush) begin
            state_d = IDLE;
            conf_d  = '0;
        end
    end

    // State and table registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            last_q  <= '0;
            dir_q   <= '0;
            conf_q  <= '0;
            vptr_q  <= '0;
            state_q <= IDLE;
            base_q  <= '0;
            pdir_q  <= 1'b0;
            page_q  <= '0;
            k_q     <= '0;
        end else begin
            valid_q <= valid_d;
            last_q  <= last_d;
            dir_q   <= dir_d;
            conf_q  <= conf_d;
            vptr_q  <= vptr_d;
            state_q <= state_d;
            base_q  <= base_d;
            pdir_q  <= pdir_d;
            page_q  <= page_d;
            k_q     <= k_d;
        end
    end

    assign pf_valid = (state_q == ISSUE);
    assign busy     = (state_q == ISSUE);
    assign pf_addr  = pf_valid ? line_addr(base_q, pdir_q, k_q) : 32'd0;

endmodule

// File: tb/tb_stream_prefetch.sv
// Scoreboard bench: expected prefetch addresses are queued with the stimulus and
// popped on every accepted request of either DUT instance.
module tb_stream_prefetch;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        miss_valid = 1'b0, miss_valid2 = 1'b0;
    logic [31:0] miss_addr = '0, miss_addr2 = '0;
    logic        flush = 1'b0, flush2 = 1'b0;
    logic        pf_ready = 1'b0, pf_ready2 = 1'b1;
    logic        pf_valid, pf_valid2, busy, busy2;
    logic [31:0] pf_addr, pf_addr2;

    int checks = 0;
    int failures = 0;
    logic [31:0] exp_q[$];

    stream_prefetch u_dut (
        .clk(clk), .rst(rst), .miss_valid(miss_valid), .miss_addr(miss_addr), .flush(flush),
        .pf_valid(pf_valid), .pf_addr(pf_addr), .pf_ready(pf_ready), .busy(busy)
    );

    stream_prefetch #(.NUM_STREAMS(2)) u_dut2 (
        .clk(clk), .rst(rst), .miss_valid(miss_valid2), .miss_addr(miss_addr2), .flush(flush2),
        .pf_valid(pf_valid2), .pf_addr(pf_addr2), .pf_ready(pf_ready2), .busy(busy2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Accepted requests are compared against the scoreboard head.
    always @(negedge clk) begin
        if (!rst && pf_valid && pf_ready) begin
            if (exp_q.size() == 0) chk("unexpected_pf", pf_addr, 32'hFFFF_FFFF);
            else chk("pf_addr", pf_addr, exp_q.pop_front());
        end
        if (!rst && pf_valid2 && pf_ready2) begin
            if (exp_q.size() == 0) chk("unexpected_pf2", pf_addr2, 32'hFFFF_FFFF);
            else chk("pf_addr2", pf_addr2, exp_q.pop_front());
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        miss_valid = 1'b0; miss_valid2 = 1'b0; flush = 1'b0; flush2 = 1'b0;
        exp_q.delete();
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic do_miss(input logic [31:0] a, input bit sel2);
        if (sel2) begin miss_valid2 = 1'b1; miss_addr2 = a; end
        else begin miss_valid = 1'b1; miss_addr = a; end
        step();
        miss_valid = 1'b0;
        miss_valid2 = 1'b0;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 20; i++) begin
            if (exp_q.size() == 0 && !busy && !busy2) break;
            step();
        end
        chk({tag, "_left"}, exp_q.size(), 0);
        chk({tag, "_busy"}, {30'd0, busy, busy2}, 32'd0);
    endtask

    initial begin
        // Reset state
        #2;
        chk("rst_pf_valid", {31'd0, pf_valid}, 32'd0);
        chk("rst_pf_addr", pf_addr, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        do_reset();
        chk("post_rst_valid", {31'd0, pf_valid}, 32'd0);

        // Ascending stream
        pf_ready = 1'b1;
        exp_q.push_back(32'h1060); exp_q.push_back(32'h1080);
        do_miss(32'h1000, 0); do_miss(32'h1020, 0); do_miss(32'h1040, 0);
        chk("up_latency", {31'd0, pf_valid}, 32'd1);
        chk("up_busy", {31'd0, busy}, 32'd1);
        drain("up");

        // Descending stream
        do_reset();
        exp_q.push_back(32'h2020); exp_q.push_back(32'h2000);
        do_miss(32'h2080, 0); do_miss(32'h2060, 0); do_miss(32'h2040, 0);
        chk("dn_latency", {31'd0, pf_valid}, 32'd1);
        drain("dn");

        // Page boundary: 0x2000 must never be requested
        do_reset();
        exp_q.push_back(32'h1FE0);
        do_miss(32'h1F80, 0); do_miss(32'h1FA0, 0); do_miss(32'h1FC0, 0);
        drain("page");
        step();
        chk("page_idle", {31'd0, pf_valid}, 32'd0);

        // Backpressure holds the request
        do_reset();
        pf_ready = 1'b0;
        exp_q.push_back(32'h1060); exp_q.push_back(32'h1080);
        do_miss(32'h1000, 0); do_miss(32'h1020, 0); do_miss(32'h1040, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_valid", {31'd0, pf_valid}, 32'd1);
            chk("stall_addr", pf_addr, 32'h1060);
            step();
        end
        pf_ready = 1'b1;
        @(negedge clk);
        chk("stall_last_valid", {31'd0, pf_valid}, 32'd1);
        drain("stall");

        // Flush aborts the burst and clears confidence
        do_reset();
        exp_q.push_back(32'h1060);
        do_miss(32'h1000, 0); do_miss(32'h1020, 0); do_miss(32'h1040, 0);
        step();
        pf_ready = 1'b0;
        flush = 1'b1;
        step();
        flush = 1'b0;
        pf_ready = 1'b1;
        chk("flush_valid", {31'd0, pf_valid}, 32'd0);
        chk("flush_left", exp_q.size(), 0);
        do_miss(32'h1060, 0);
        chk("flush_retrain", {31'd0, busy}, 32'd0);
        step();
        chk("flush_retrain2", {31'd0, pf_valid}, 32'd0);

        // Flush coinciding with a miss drops that miss
        do_reset();
        do_miss(32'h3000, 0); do_miss(32'h3020, 0);
        flush = 1'b1;
        do_miss(32'h3040, 0);
        flush = 1'b0;
        chk("flush_miss", {31'd0, busy}, 32'd0);

        // Asynchronous reset mid-burst
        do_reset();
        pf_ready = 1'b0;
        do_miss(32'h1000, 0); do_miss(32'h1020, 0); do_miss(32'h1040, 0);
        chk("mid_valid", {31'd0, pf_valid}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_valid", {31'd0, pf_valid}, 32'd0);
        chk("async_addr", pf_addr, 32'd0);
        chk("async_busy", {31'd0, busy}, 32'd0);
        step();
        rst = 1'b0;
        pf_ready = 1'b1;
        do_miss(32'h1060, 0);
        chk("async_cleared", {31'd0, busy}, 32'd0);

        // Two-entry table: 0x4000 evicts entry 0, the 0x8000 stream survives
        do_reset();
        do_miss(32'h1000, 1); do_miss(32'h8000, 1);
        do_miss(32'h1020, 1); do_miss(32'h8020, 1);
        do_miss(32'h4000, 1);
        exp_q.push_back(32'h8060); exp_q.push_back(32'h8080);
        do_miss(32'h8040, 1);
        chk("evict_trigger", {31'd0, pf_valid2}, 32'd1);
        drain("evict");
        do_miss(32'h1040, 1);
        chk("evict_gone", {31'd0, busy2}, 32'd0);
        step();
        chk("evict_gone2", {31'd0, pf_valid2}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
